router_fsm_np: RTL and testbench
================================

ROUTER_FSM_NP -- requirements
Module: router_fsm_np

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Parameter NUM_PORTS, default 3: number of output FIFOs/ports; legal range 2..16.
REQ-003 Parameter ADDR_W, default 2: width of the address field; SHALL be at least clog2(NUM_PORTS).
REQ-004 Parameter WAIT_TIMEOUT, default 30: cycles allowed in WAIT_TILL_EMPTY before the packet is dropped; 0 disables the timeout.
REQ-005 clock  in  1  system clock, all state changes on the rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 pkt_valid  in  1  source packet-valid.
REQ-008 data_in  in  ADDR_W  address field of the header byte.
REQ-009 fifo_full  in  1  full flag of the currently selected FIFO.
REQ-010 fifo_empty  in  NUM_PORTS  per-port FIFO empty flags.
REQ-011 soft_reset  in  NUM_PORTS  per-port soft-reset (read-timeout) flags.
REQ-012 parity_done  in  1  parity byte has been written (from the register block).
REQ-013 low_pkt_valid  in  1  pkt_valid fell while the FSM was in FIFO_FULL_STATE (from the register block).
REQ-014 The outputs write_enb_reg, detect_add, ld_state, laf_state, lfd_state, full_state, rst_int_reg and busy SHALL each be 1 bit wide.
REQ-015 dest_sel  out  NUM_PORTS  one-hot code of the latched destination port.
REQ-016 drop_state  out  1  FSM is discarding the packet.
REQ-017 addr_err  out  1  one-cycle pulse when a header carries an address of NUM_PORTS or greater.
REQ-018 wait_timeout  out  1  one-cycle pulse when WAIT_TILL_EMPTY expires.

Function
REQ-019 The FSM SHALL have nine states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY and DROP_PACKET.
REQ-020 In DECODE_ADDRESS, when pkt_valid=1, the FSM SHALL latch data_in into addr_q in the same cycle.
REQ-021 Transitions out of DECODE_ADDRESS SHALL be:
- pkt_valid=1 and data_in<NUM_PORTS and fifo_empty[data_in]=1 -> LOAD_FIRST_DATA.
- pkt_valid=1 and data_in<NUM_PORTS and fifo_empty[data_in]=0 -> WAIT_TILL_EMPTY.
- pkt_valid=1 and data_in>=NUM_PORTS -> DROP_PACKET, with addr_err pulsed on the next cycle.
- otherwise -> hold.
REQ-022 LOAD_FIRST_DATA SHALL go unconditionally to LOAD_DATA.
REQ-023 LOAD_DATA SHALL go to FIFO_FULL_STATE if fifo_full=1, to LOAD_PARITY if fifo_full=0 and pkt_valid=0, and SHALL hold otherwise.
REQ-024 FIFO_FULL_STATE SHALL go to LOAD_AFTER_FULL when fifo_full=0, and SHALL hold otherwise.
REQ-025 Transitions out of LOAD_AFTER_FULL SHALL be:
- parity_done=1 -> DECODE_ADDRESS.
- parity_done=0 and low_pkt_valid=1 -> LOAD_PARITY.
- parity_done=0 and low_pkt_valid=0 -> LOAD_DATA.
REQ-026 LOAD_PARITY SHALL go to CHECK_PARITY_ERROR; CHECK_PARITY_ERROR SHALL go to FIFO_FULL_STATE if fifo_full=1 and to DECODE_ADDRESS otherwise.
REQ-027 WAIT_TILL_EMPTY SHALL go to LOAD_FIRST_DATA when fifo_empty[addr_q]=1.
REQ-028 WAIT_TILL_EMPTY SHALL go to DROP_PACKET, pulsing wait_timeout, when its wait counter reaches WAIT_TIMEOUT; a fifo_empty arriving in the same cycle SHALL win over the timeout.
REQ-029 The wait counter SHALL clear on entry to WAIT_TILL_EMPTY and SHALL saturate, never wrap.
REQ-030 DROP_PACKET SHALL hold while pkt_valid=1 and SHALL go to DECODE_ADDRESS when pkt_valid=0.
REQ-031 soft_reset[addr_q]=1 in any state other than DECODE_ADDRESS and DROP_PACKET SHALL force DECODE_ADDRESS on the next edge, with priority over all other transitions.
REQ-032 Soft-reset bits of other ports SHALL be ignored.
REQ-033 Outputs SHALL be Moore-decoded from the state:
- detect_add = DECODE_ADDRESS; lfd_state = LOAD_FIRST_DATA; ld_state = LOAD_DATA; laf_state = LOAD_AFTER_FULL; full_state = FIFO_FULL_STATE; rst_int_reg = CHECK_PARITY_ERROR; drop_state = DROP_PACKET.
- write_enb_reg = 1 in LOAD_DATA, LOAD_PARITY or LOAD_AFTER_FULL.
- busy = 1 in every state except DECODE_ADDRESS, LOAD_DATA and DROP_PACKET.
REQ-034 dest_sel SHALL equal the one-hot code of addr_q while not in DECODE_ADDRESS or DROP_PACKET, and SHALL be 0 otherwise.

Reset
REQ-035 reset=1 SHALL, at the next edge:
- set state to DECODE_ADDRESS, addr_q to 0 and the wait counter to 0;
- give detect_add=1 and all other outputs 0;
- override soft_reset and any packet in progress.

Structure
REQ-036 The state enum, its encoding and the default parameters SHALL live in the shared package router_pkg.
REQ-037 The wait counter SHALL be a sub-module, router_wait_timer (inputs clear/enable, output expired).

Verification
REQ-038 The bench SHALL cover these directed scenarios:
- Header addr=1, fifo_empty=3'b010, 3 payload cycles, then pkt_valid=0 -> DECODE, LFD, LD x3, LP, CPE, DECODE; dest_sel=3'b010.
- fifo_full=1 in LOAD_DATA for 2 cycles -> FIFO_FULL_STATE for 2 cycles, then LAF; with low_pkt_valid=1, LP follows.
- Header addr=3 with NUM_PORTS=3 -> addr_err pulses once, drop_state=1 until pkt_valid=0, then detect_add=1.
- Header addr=2, fifo_empty[2]=0, WAIT_TIMEOUT=4 -> busy=1 for 4 cycles in WAIT, wait_timeout pulses once, then DROP_PACKET.
- soft_reset[1]=1 mid-LOAD_DATA on port 1 -> detect_add=1 next cycle; soft_reset[0] at the same point -> no effect.
- reset=1 in FIFO_FULL_STATE -> next cycle detect_add=1, all other outputs 0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the packet router FSM: state encoding and default parameters.
package router_pkg;

  localparam int DEF_NUM_PORTS    = 3;
  localparam int DEF_ADDR_W       = 2;
  localparam int DEF_WAIT_TIMEOUT = 30;

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    FIFO_FULL_STATE    = 4'd3,
    LOAD_AFTER_FULL    = 4'd4,
    LOAD_PARITY        = 4'd5,
    CHECK_PARITY_ERROR = 4'd6,
    WAIT_TILL_EMPTY    = 4'd7,
    DROP_PACKET        = 4'd8
  } router_state_t;

  // Counter width able to hold the wait limit (at least one bit).
  function automatic int timer_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Saturating cycle counter that flags when a wait has lasted LIMIT cycles.
// LIMIT = 0 disables the flag entirely.
module router_wait_timer
  import router_pkg::*;
#(
  parameter int LIMIT = DEF_WAIT_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CNT_W    = timer_width(LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = (LIMIT > 0) ? CNT_W'(LIMIT - 1) : '0;

  logic [CNT_W-1:0] r_count;

  // Count enabled cycles; hold at the top value instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // The count starts at 0 in the first waiting cycle, so LIMIT-1 marks the last allowed cycle.
  assign expired = (LIMIT != 0) && enable && (r_count >= CNT_LAST);

endmodule

// File: rtl/router_fsm_np.sv
// Router control FSM: decodes the header address, sequences payload/parity
// loads into the selected FIFO, waits for a busy FIFO (with timeout) and
// discards packets with illegal addresses or expired waits.
module router_fsm_np
  import router_pkg::*;
#(
  parameter int NUM_PORTS    = DEF_NUM_PORTS,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int WAIT_TIMEOUT = DEF_WAIT_TIMEOUT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic                 write_enb_reg,
  output logic                 detect_add,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 lfd_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 busy,
  output logic [NUM_PORTS-1:0] dest_sel,
  output logic                 drop_state,
  output logic                 addr_err,
  output logic                 wait_timeout
);

  // Port count widened by one bit so any ADDR_W-bit address compares cleanly.
  localparam logic [ADDR_W:0] PORT_LIMIT = (ADDR_W + 1)'(NUM_PORTS);

  router_state_t     r_state;
  router_state_t     w_state_nxt;
  logic [ADDR_W-1:0] r_addr_q;
  logic              r_addr_err;
  logic              r_wait_to;

  logic w_hdr_ok;
  logic w_hdr_empty;
  logic w_dst_empty;
  logic w_sr_hit;
  logic w_in_packet;
  logic w_waiting;
  logic w_expired;

  // Select one port's flag by address; addresses past the last port read as 0.
  function automatic logic port_bit(input logic [NUM_PORTS-1:0] bits,
                                    input logic [ADDR_W-1:0]    addr);
    logic b;
    b = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (addr == ADDR_W'(i)) b = bits[i];
    end
    return b;
  endfunction

  assign w_hdr_ok    = ({1'b0, data_in} < PORT_LIMIT);
  assign w_hdr_empty = port_bit(fifo_empty, data_in);
  assign w_dst_empty = port_bit(fifo_empty, r_addr_q);
  assign w_in_packet = (r_state != DECODE_ADDRESS) && (r_state != DROP_PACKET);
  assign w_sr_hit    = w_in_packet && port_bit(soft_reset, r_addr_q);
  assign w_waiting   = (r_state == WAIT_TILL_EMPTY);

  router_wait_timer #(
    .LIMIT(WAIT_TIMEOUT)
  ) u_wait_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (!w_waiting),
    .enable (w_waiting),
    .expired(w_expired)
  );

  // State, latched address and the registered one-cycle error pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= DECODE_ADDRESS;
      r_addr_q   <= '0;
      r_addr_err <= 1'b0;
      r_wait_to  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == DECODE_ADDRESS) && pkt_valid) r_addr_q <= data_in;
      r_addr_err <= (r_state == DECODE_ADDRESS) && pkt_valid && !w_hdr_ok;
      r_wait_to  <= w_waiting && !w_sr_hit && !w_dst_empty && w_expired;
    end
  end

  // Next-state logic; a soft reset of the active port overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    if (w_sr_hit) begin
      w_state_nxt = DECODE_ADDRESS;
    end else begin
      case (r_state)
        DECODE_ADDRESS: begin
          if (pkt_valid) begin
            if (!w_hdr_ok)        w_state_nxt = DROP_PACKET;
            else if (w_hdr_empty) w_state_nxt = LOAD_FIRST_DATA;
            else                  w_state_nxt = WAIT_TILL_EMPTY;
          end
        end
        LOAD_FIRST_DATA: w_state_nxt = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       w_state_nxt = FIFO_FULL_STATE;
          else if (!pkt_valid) w_state_nxt = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) w_state_nxt = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        w_state_nxt = DECODE_ADDRESS;
          else if (low_pkt_valid) w_state_nxt = LOAD_PARITY;
          else                    w_state_nxt = LOAD_DATA;
        end
        LOAD_PARITY: w_state_nxt = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          w_state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        WAIT_TILL_EMPTY: begin
          // An empty FIFO in the same cycle as expiry still takes the packet.
          if (w_dst_empty)    w_state_nxt = LOAD_FIRST_DATA;
          else if (w_expired) w_state_nxt = DROP_PACKET;
        end
        DROP_PACKET: begin
          if (!pkt_valid) w_state_nxt = DECODE_ADDRESS;
        end
        default: w_state_nxt = DECODE_ADDRESS;
      endcase
    end
  end

  // Moore output decode from the current state.
  always_comb begin
    detect_add    = (r_state == DECODE_ADDRESS);
    lfd_state     = (r_state == LOAD_FIRST_DATA);
    ld_state      = (r_state == LOAD_DATA);
    laf_state     = (r_state == LOAD_AFTER_FULL);
    full_state    = (r_state == FIFO_FULL_STATE);
    rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
    drop_state    = (r_state == DROP_PACKET);
    write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                    (r_state == LOAD_AFTER_FULL);
    busy          = (r_state != DECODE_ADDRESS) && (r_state != LOAD_DATA) &&
                    (r_state != DROP_PACKET);
    dest_sel      = '0;
    if (w_in_packet) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        dest_sel[i] = (r_addr_q == ADDR_W'(i));
      end
    end
  end

  assign addr_err     = r_addr_err;
  assign wait_timeout = r_wait_to;

endmodule

// File: tb/tb_router_fsm_np.sv
// Bench for router_fsm_np: directed packet scenarios followed by random
// stimulus, all compared every cycle against a packet-level reference model.
module tb_router_fsm_np;

  localparam int NP = 3;
  localparam int AW = 2;
  localparam int WT = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          pkt_valid;
  logic [AW-1:0] data_in;
  logic          fifo_full;
  logic [NP-1:0] fifo_empty;
  logic [NP-1:0] soft_reset;
  logic          parity_done;
  logic          low_pkt_valid;
  logic          write_enb_reg, detect_add, ld_state, laf_state, lfd_state;
  logic          full_state, rst_int_reg, busy, drop_state, addr_err, wait_timeout;
  logic [NP-1:0] dest_sel;

  always #5 clock = ~clock;

  router_fsm_np #(
    .NUM_PORTS(NP), .ADDR_W(AW), .WAIT_TIMEOUT(WT)
  ) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .write_enb_reg(write_enb_reg), .detect_add(detect_add), .ld_state(ld_state),
    .laf_state(laf_state), .lfd_state(lfd_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .busy(busy), .dest_sel(dest_sel),
    .drop_state(drop_state), .addr_err(addr_err), .wait_timeout(wait_timeout)
  );

  // Packet phases of the reference model.
  localparam int P_DEC = 0, P_LFD = 1, P_LD = 2, P_FULL = 3, P_LAF = 4;
  localparam int P_LP = 5, P_CPE = 6, P_WAIT = 7, P_DROP = 8;

  int m_ph = P_DEC;
  int m_addr = 0;
  int m_waited = 0;
  bit m_aerr = 1'b0;
  bit m_wto = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  int n_cyc = 0;

  function automatic logic [13:0] model_outs();
    logic [NP-1:0] ds;
    logic we, bz;
    ds = '0;
    if (m_ph != P_DEC && m_ph != P_DROP && m_addr < NP) ds[m_addr] = 1'b1;
    we = (m_ph == P_LD) || (m_ph == P_LP) || (m_ph == P_LAF);
    bz = !((m_ph == P_DEC) || (m_ph == P_LD) || (m_ph == P_DROP));
    return {we, m_ph == P_DEC, m_ph == P_LD, m_ph == P_LAF, m_ph == P_LFD,
            m_ph == P_FULL, m_ph == P_CPE, bz, m_ph == P_DROP, m_aerr, m_wto, ds};
  endfunction

  task automatic model_step();
    bit sr;
    if (reset) begin
      m_ph = P_DEC; m_addr = 0; m_waited = 0; m_aerr = 0; m_wto = 0;
      return;
    end
    m_aerr = 0;
    m_wto  = 0;
    sr = (m_ph != P_DEC) && (m_ph != P_DROP) && (m_addr < NP) && soft_reset[m_addr];
    if (sr) begin
      m_ph = P_DEC;
      return;
    end
    case (m_ph)
      P_DEC: if (pkt_valid) begin
        m_addr = int'(data_in);
        if (m_addr >= NP) begin m_ph = P_DROP; m_aerr = 1; end
        else if (fifo_empty[m_addr]) m_ph = P_LFD;
        else begin m_ph = P_WAIT; m_waited = 0; end
      end
      P_LFD:  m_ph = P_LD;
      P_LD:   if (fifo_full) m_ph = P_FULL; else if (!pkt_valid) m_ph = P_LP;
      P_FULL: if (!fifo_full) m_ph = P_LAF;
      P_LAF:  m_ph = parity_done ? P_DEC : (low_pkt_valid ? P_LP : P_LD);
      P_LP:   m_ph = P_CPE;
      P_CPE:  m_ph = fifo_full ? P_FULL : P_DEC;
      P_WAIT: begin
        m_waited++;
        if (fifo_empty[m_addr]) m_ph = P_LFD;
        else if (m_waited >= WT) begin m_ph = P_DROP; m_wto = 1; end
      end
      P_DROP: if (!pkt_valid) m_ph = P_DEC;
      default: m_ph = P_DEC;
    endcase
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic cyc();
    logic [13:0] act, exp;
    @(posedge clock);
    model_step();
    #1;
    n_cyc++;
    act = {write_enb_reg, detect_add, ld_state, laf_state, lfd_state, full_state,
           rst_int_reg, busy, drop_state, addr_err, wait_timeout, dest_sel};
    exp = model_outs();
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL cycle%0d outputs(we,det,ld,laf,lfd,full,rst,busy,drop,aerr,wto,dest) got %b want %b",
               n_cyc, act, exp);
    end
    #1;
  endtask

  task automatic chk(input string nm, input logic [13:0] act, input logic [13:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    reset = 0; pkt_valid = 0; data_in = '0; fifo_full = 0; fifo_empty = '1;
    soft_reset = '0; parity_done = 0; low_pkt_valid = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    cyc(); cyc();
    chk("reset_detect", 14'(detect_add), 14'd1);
    chk("reset_busy", 14'(busy), 14'd0);
    chk("reset_dest", 14'(dest_sel), 14'd0);
    reset = 0;
    cyc();

    // Normal packet to port 1 with three payload cycles.
    pkt_valid = 1; data_in = 2'd1; fifo_empty = 3'b010;
    cyc();
    chk("s1_lfd", 14'(lfd_state), 14'd1);
    chk("s1_dest", 14'(dest_sel), 14'b010);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("s1_ld", 14'(ld_state), 14'd1);
    end
    pkt_valid = 0;
    cyc(); chk("s1_lp_we", 14'(write_enb_reg), 14'd1);
    cyc(); chk("s1_cpe", 14'(rst_int_reg), 14'd1);
    cyc(); chk("s1_done", 14'(detect_add), 14'd1);

    // FIFO full for two cycles during load, then parity after full.
    idle(); pkt_valid = 1; data_in = 2'd0; fifo_empty = 3'b001;
    cyc(); cyc();
    fifo_full = 1;
    cyc(); chk("s2_full1", 14'(full_state), 14'd1);
    cyc(); chk("s2_full2", 14'(full_state), 14'd1);
    fifo_full = 0;
    cyc(); chk("s2_laf", 14'({laf_state, write_enb_reg}), 14'b11);
    low_pkt_valid = 1;
    cyc(); chk("s2_lp", 14'({write_enb_reg, busy, ld_state}), 14'b110);
    pkt_valid = 0; low_pkt_valid = 0;
    cyc(); cyc();
    chk("s2_done", 14'(detect_add), 14'd1);

    // Illegal address.
    idle(); pkt_valid = 1; data_in = 2'd3;
    cyc(); chk("s3_aerr", 14'({addr_err, drop_state}), 14'b11);
    cyc(); chk("s3_aerr_once", 14'({addr_err, drop_state}), 14'b01);
    pkt_valid = 0;
    cyc(); chk("s3_back", 14'(detect_add), 14'd1);

    // Destination never drains: time out after four waiting cycles.
    idle(); pkt_valid = 1; data_in = 2'd2; fifo_empty = 3'b011;
    for (int i = 0; i < WT; i++) begin
      cyc();
      chk("s4_wait", 14'({busy, wait_timeout, drop_state}), 14'b100);
    end
    cyc(); chk("s4_timeout", 14'({busy, wait_timeout, drop_state}), 14'b011);
    cyc(); chk("s4_pulse_once", 14'({wait_timeout, drop_state}), 14'b01);
    pkt_valid = 0;
    cyc(); chk("s4_back", 14'(detect_add), 14'd1);

    // Soft reset: other port ignored, own port aborts the packet.
    idle(); pkt_valid = 1; data_in = 2'd1; fifo_empty = 3'b010;
    cyc(); cyc();
    soft_reset = 3'b001;
    cyc(); chk("s5_other_port", 14'(ld_state), 14'd1);
    soft_reset = 3'b010;
    cyc(); chk("s5_abort", 14'(detect_add), 14'd1);

    // Hard reset while in FIFO_FULL_STATE.
    idle(); pkt_valid = 1; data_in = 2'd0; fifo_empty = 3'b001;
    cyc(); cyc();
    fifo_full = 1;
    cyc(); chk("s6_full", 14'(full_state), 14'd1);
    reset = 1;
    cyc();
    chk("s6_reset", {write_enb_reg, detect_add, ld_state, laf_state, lfd_state, full_state,
                     rst_int_reg, busy, drop_state, addr_err, wait_timeout, dest_sel},
        14'b01000000000000);
    idle();
    cyc();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 63) == 0);
      pkt_valid     = ($urandom_range(0, 3) != 0);
      data_in       = AW'($urandom_range(0, 3));
      fifo_full     = ($urandom_range(0, 3) == 0);
      fifo_empty    = NP'($urandom_range(0, 7));
      soft_reset    = ($urandom_range(0, 15) == 0) ? NP'($urandom_range(1, 7)) : '0;
      parity_done   = ($urandom_range(0, 3) == 0);
      low_pkt_valid = ($urandom_range(0, 1) == 0);
      cyc();
    end
    idle();
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
